zapper_src_arbiter: RTL and testbench
=====================================

// Module: zapper_src_arbiter
// PURPOSE
//  Shares the zapper's pointer/trigger input between two requesters: the PS/2 mouse and the analog stick.
//  Sits between the HPS input bus and the zapper block.
//  Drives the zapper's mode select, and gates the mouse packet stream and analog trigger into it.
//  Auto-switches ownership on activity of the idle source, with holdoff and a transfer drain; user may force a source.
// PARAMETERS
//  DEADZONE     16         |stick axis| must exceed this (signed 8-bit) to count as analog activity
//  HOLD_CYCLES  2_000_000  owner-idle cycles required before the other source may take ownership
//  XFER_CYCLES  65_536     drain cycles after an ownership change; trigger and packets suppressed
// PORTS
//  clk             in   1   system clock
//  reset           in   1   asynchronous, active-high reset
//  ps2_mouse       in   25  {pkt toggle[24], dy[23:16], dx[15:8], ctrl[7:0]}; ctrl[0]=left btn
//  analog          in   16  {joy_y[15:8], joy_x[7:0]}, two's complement
//  analog_trigger  in   1   stick trigger button, level
//  force_src       in   2   00 auto, 01 force mouse, 10 force analog, 11 = auto
//  mode            out  1   to zapper: 0 mouse owns, 1 analog owns
//  mouse_fwd       out  25  gated/registered ps2_mouse to zapper
//  trig_fwd        out  1   gated analog_trigger to zapper
//  owner_chg       out  1   one-cycle pulse on each ownership change
//  busy            out  1   high while in XFER
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain, clk. reset is async, active-high.
//  - Reset values: mode=0, mouse_fwd=0, trig_fwd=0, owner_chg=0, busy=0.
//  - Reset state: OWN_M with idle_cnt=0 and xfer_cnt=0. Reset mid-XFER aborts the drain.
//  Activity detection (registered inputs)
//  - m_act = packet edge (ps2_mouse[24] != previous registered value) AND (dx!=0 | dy!=0 | ctrl[0]).
//  - a_act = |joy_x|>DEADZONE | |joy_y|>DEADZONE | analog_trigger.
//  - |v| is computed 9-bit signed, so -128 -> 128 (active).
//  Idle counter
//  - idle_cnt is 32-bit, saturating at HOLD_CYCLES.
//  - Cleared on owner activity; otherwise increments each cycle.
//  - Cleared on entry to any state.
//  States
//  - OWN_M: mode=0.
//    -> XFER(target A) if force_src==10,
//       or if auto AND a_act AND idle_cnt==HOLD_CYCLES AND !m_act in the same cycle.
//  - OWN_A: mode=1. Symmetric to OWN_M, using m_act and force_src==01.
//  - XFER: mode=target (already switched on entry); busy=1; xfer_cnt counts up to XFER_CYCLES-1.
//    -> OWN_<target> when the count completes.
//    force_src changing to the opposite source mid-XFER retargets and restarts xfer_cnt, with another owner_chg pulse.
//  - owner_chg pulses in the cycle mode changes (the XFER entry cycle).
//  Simultaneous activity and force
//  - Owner activity in the same cycle as non-owner activity: owner keeps ownership.
//  - force_src overrides activity and holdoff and takes effect on the next clock.
//  - Forcing the current owner: no transition.
//  Gating (1-cycle latency, registered)
//  - mouse_fwd <= ps2_mouse only in OWN_M; otherwise mouse_fwd holds its last value, so bit 24 makes no edge.
//  - trig_fwd <= analog_trigger only in OWN_A; forced 0 in OWN_M and XFER.
//  - No trigger crosses an ownership change: a button held through XFER must be released before it reaches the zapper.
//    While in OWN_A, trig_fwd stays 0 until analog_trigger is seen low once after entry.
// TESTING
//  Test parameters: DEADZONE=16, HOLD_CYCLES=100, XFER_CYCLES=8.
//  1. Reset then mouse packets dx=5: mode=0; mouse_fwd mirrors ps2_mouse 1 cycle later; owner_chg never pulses.
//  2. Mouse idle 100 cycles, then joy_x=+40: owner_chg pulse, mode=1, busy for 8 cycles, then OWN_A.
//     Mouse packets sent during this leave mouse_fwd[24] frozen.
//  3. joy_x=+16 (inside DEADZONE) or joy_x=-128 after mouse idle: first causes no switch; second switches.
//  4. analog_trigger held high across the XFER into OWN_A: trig_fwd stays 0; release then press gives trig_fwd=1 one cycle after the press.
//  5. Same cycle m_act and a_act while OWN_M with idle_cnt saturated: stays OWN_M. force_src=10: switch next clock regardless of idle_cnt.
//  6. Assert reset mid-XFER (xfer_cnt=4): all outputs 0 immediately; after release mode=0 in OWN_M.

Source files
------------

// File: rtl/zapper_src_if.sv
// Bundle between the HPS input side and the zapper: requester inputs in, gated zapper feed out.
interface zapper_src_if;
  logic [24:0] ps2_mouse;
  logic [15:0] analog;
  logic        analog_trigger;
  logic [1:0]  force_src;
  logic        mode;
  logic [24:0] mouse_fwd;
  logic        trig_fwd;
  logic        owner_chg;
  logic        busy;

  modport master (
    output ps2_mouse, analog, analog_trigger, force_src,
    input  mode, mouse_fwd, trig_fwd, owner_chg, busy
  );

  modport slave (
    input  ps2_mouse, analog, analog_trigger, force_src,
    output mode, mouse_fwd, trig_fwd, owner_chg, busy
  );
endinterface

// File: rtl/zapper_src_arbiter.sv
// Arbitrates the zapper pointer/trigger between PS/2 mouse and analog stick, with
// idle holdoff before auto-takeover and a drain window after every ownership change.
module zapper_src_arbiter #(
  parameter int DEADZONE    = 16,
  parameter int HOLD_CYCLES = 2_000_000,
  parameter int XFER_CYCLES = 65_536
) (
  input  logic         clk,
  input  logic         reset,
  zapper_src_if.slave  bus
);
  localparam logic signed [8:0] DZ9   = 9'(DEADZONE);
  localparam logic [31:0]       HOLD  = 32'(HOLD_CYCLES);
  localparam logic [31:0]       XLAST = 32'(XFER_CYCLES - 1);

  typedef enum logic [1:0] {OWN_M, OWN_A, XFER} state_e;

  state_e      state_q, state_d;
  logic        tgt_q, tgt_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] xfer_q, xfer_d;
  logic        pkt_q;
  logic        arm_q, arm_d;
  logic [24:0] mfwd_q, mfwd_d;
  logic        trig_q, trig_d;
  logic        mode_q, mode_d;
  logic        chg_q, chg_d;
  logic        busy_q, busy_d;

  logic m_act, a_act, auto_sel, force_m, force_a;

  // 9-bit magnitude so that -128 maps to +128 instead of wrapping.
  function automatic logic over_dz(input logic [7:0] v);
    logic signed [8:0] s;
    s = $signed({v[7], v});
    if (s < 0) s = -s;
    return s > DZ9;
  endfunction

  always_comb begin
    m_act    = (bus.ps2_mouse[24] != pkt_q) &&
               ((|bus.ps2_mouse[15:8]) || (|bus.ps2_mouse[23:16]) || bus.ps2_mouse[0]);
    a_act    = over_dz(bus.analog[7:0]) || over_dz(bus.analog[15:8]) || bus.analog_trigger;
    force_m  = (bus.force_src == 2'b01);
    force_a  = (bus.force_src == 2'b10);
    auto_sel = !force_m && !force_a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OWN_M;
      tgt_q   <= 1'b0;
      idle_q  <= '0;
      xfer_q  <= '0;
      pkt_q   <= 1'b0;
      arm_q   <= 1'b0;
      mfwd_q  <= '0;
      trig_q  <= 1'b0;
      mode_q  <= 1'b0;
      chg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      idle_q  <= idle_d;
      xfer_q  <= xfer_d;
      pkt_q   <= bus.ps2_mouse[24];
      arm_q   <= arm_d;
      mfwd_q  <= mfwd_d;
      trig_q  <= trig_d;
      mode_q  <= mode_d;
      chg_q   <= chg_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    idle_d  = idle_q;
    xfer_d  = xfer_q;
    chg_d   = 1'b0;

    unique case (state_q)
      OWN_M: begin
        if (m_act)              idle_d = '0;
        else if (idle_q != HOLD) idle_d = idle_q + 32'd1;
        if (force_a || (auto_sel && a_act && !m_act && idle_q == HOLD)) begin
          state_d = XFER;
          tgt_d   = 1'b1;
          idle_d  = '0;
          xfer_d  = '0;
          chg_d   = 1'b1;
        end
      end
      OWN_A: begin
        if (a_act)              idle_d = '0;
        else if (idle_q != HOLD) idle_d = idle_q + 32'd1;
        if (force_m || (auto_sel && m_act && !a_act && idle_q == HOLD)) begin
          state_d = XFER;
          tgt_d   = 1'b0;
          idle_d  = '0;
          xfer_d  = '0;
          chg_d   = 1'b1;
        end
      end
      XFER: begin
        // A force toward the non-target source restarts the drain in the other direction.
        if ((tgt_q && force_m) || (!tgt_q && force_a)) begin
          tgt_d  = !tgt_q;
          xfer_d = '0;
          chg_d  = 1'b1;
        end else if (xfer_q == XLAST) begin
          state_d = tgt_q ? OWN_A : OWN_M;
          idle_d  = '0;
          xfer_d  = '0;
        end else begin
          xfer_d = xfer_q + 32'd1;
        end
      end
      default: state_d = OWN_M;
    endcase

    mode_d = (state_d == XFER) ? tgt_d : (state_d == OWN_A);
    busy_d = (state_d == XFER);

    // Forwarding only while ownership is stable across this edge, so nothing leaks into a drain.
    mfwd_d = (state_q == OWN_M && state_d == OWN_M) ? bus.ps2_mouse : mfwd_q;
    arm_d  = (state_q == OWN_A) ? (arm_q || !bus.analog_trigger) : 1'b0;
    trig_d = (state_q == OWN_A) && (state_d == OWN_A) && arm_q && bus.analog_trigger;
  end

  assign bus.mode      = mode_q;
  assign bus.mouse_fwd = mfwd_q;
  assign bus.trig_fwd  = trig_q;
  assign bus.owner_chg = chg_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_zapper_src_arbiter.sv
// Randomized scoreboard bench for zapper_src_arbiter against a cycle-level ownership model.
module tb_zapper_src_arbiter;
  localparam int DZ = 16, HOLD = 100, XF = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zapper_src_if bus();

  zapper_src_arbiter #(.DEADZONE(DZ), .HOLD_CYCLES(HOLD), .XFER_CYCLES(XF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic        mode;
    logic [24:0] mfwd;
    logic        trig;
    logic        chg;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;

  // Reference state: who owns, whether a drain is running and toward whom, counters.
  bit          m_own, in_drain, tgt, armed, prev_tog;
  int          idle, drain;
  logic [24:0] mfwd;
  logic        trigf, chg;
  logic        tog = 1'b0;

  function automatic bit big(input logic [7:0] v);
    byte b;
    int  i;
    b = v;
    i = b;
    if (i < 0) i = -i;
    return i > DZ;
  endfunction

  task automatic model(input logic r, input logic [24:0] pm, input logic [15:0] an,
                       input logic tr, input logic [1:0] fs);
    bit ma, aa, au, oact, nact, sw;
    exp_t e;
    if (r) begin
      m_own = 0; in_drain = 0; tgt = 0; armed = 0; prev_tog = 0;
      idle = 0; drain = 0; mfwd = '0; trigf = 0; chg = 0;
    end else begin
      ma = (pm[24] != prev_tog) && (pm[15:8] != 0 || pm[23:16] != 0 || pm[0]);
      aa = big(an[7:0]) || big(an[15:8]) || tr;
      au = (fs == 2'b00) || (fs == 2'b11);
      chg = 0;
      if (!in_drain) begin
        oact = m_own ? aa : ma;
        nact = m_own ? ma : aa;
        sw = (fs == (m_own ? 2'b01 : 2'b10)) || (au && nact && !oact && idle == HOLD);
        if (!m_own && !sw) mfwd = pm;
        trigf = m_own && !sw && armed && tr;
        if (m_own && !tr) armed = 1;
        if (sw) begin
          in_drain = 1; tgt = !m_own; drain = 0; idle = 0; chg = 1;
        end else begin
          idle = oact ? 0 : (idle < HOLD ? idle + 1 : HOLD);
        end
      end else begin
        trigf = 0;
        if (fs == (tgt ? 2'b01 : 2'b10)) begin
          tgt = !tgt; drain = 0; chg = 1;
        end else if (drain == XF - 1) begin
          in_drain = 0; m_own = tgt; idle = 0; armed = 0;
        end else begin
          drain++;
        end
      end
      prev_tog = pm[24];
    end
    e.mode = in_drain ? tgt : m_own;
    e.mfwd = mfwd;
    e.trig = trigf;
    e.chg  = chg;
    e.busy = in_drain;
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [24:0] pm, input logic [15:0] an,
                      input logic tr, input logic [1:0] fs);
    @(negedge clk);
    reset              = r;
    bus.ps2_mouse      = pm;
    bus.analog         = an;
    bus.analog_trigger = tr;
    bus.force_src      = fs;
    model(r, pm, an, tr, fs);
  endtask

  task automatic mpkt(input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] ctl,
                      input logic [15:0] an, input logic tr, input logic [1:0] fs);
    tog = ~tog;
    step(1'b0, {tog, dy, dx, ctl}, an, tr, fs);
  endtask

  task automatic quiet(input int n, input logic [15:0] an, input logic tr, input logic [1:0] fs);
    for (int i = 0; i < n; i++) step(1'b0, {tog, 24'h0}, an, tr, fs);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({bus.mode, bus.mouse_fwd, bus.trig_fwd, bus.owner_chg, bus.busy} !== '0) begin
      errors++;
      $display("FAIL %s: got mode=%0b mfwd=%h trig=%0b chg=%0b busy=%0b, want all 0",
               name, bus.mode, bus.mouse_fwd, bus.trig_fwd, bus.owner_chg, bus.busy);
    end
  endtask

  // Monitor: every settled cycle pops one expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.mode, bus.mouse_fwd, bus.trig_fwd, bus.owner_chg, bus.busy} !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got mode=%0b mfwd=%h trig=%0b chg=%0b busy=%0b, want mode=%0b mfwd=%h trig=%0b chg=%0b busy=%0b",
                   $time, bus.mode, bus.mouse_fwd, bus.trig_fwd, bus.owner_chg, bus.busy,
                   e.mode, e.mfwd, e.trig, e.chg, e.busy);
        end
      end
    end
  end

  initial begin
    int          kind, len;
    logic [1:0]  bfs;
    logic [15:0] an;
    logic        tr;
    byte         sb;

    reset = 1'b1;
    bus.ps2_mouse = '0; bus.analog = '0; bus.analog_trigger = 1'b0; bus.force_src = 2'b00;
    #1;
    check_zero("reset_state");
    for (int i = 0; i < 3; i++) step(1'b1, 25'h0, 16'h0, 1'b0, 2'b00);

    // Mouse packets while mouse owns.
    for (int i = 0; i < 10; i++) begin
      mpkt(8'd5, 8'd0, 8'd0, 16'h0, 1'b0, 2'b00);
      quiet(1, 16'h0, 1'b0, 2'b00);
    end

    // Mouse idle past holdoff, then stick deflection takes over; packets during drain are held off.
    quiet(102, 16'h0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, {tog, 24'h0}, 16'h0028, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      mpkt(8'd7, 8'd2, 8'd0, 16'h0, 1'b0, 2'b00);
      quiet(1, 16'h0, 1'b0, 2'b00);
    end
    quiet(10, 16'h0, 1'b0, 2'b00);

    // Stick idle past holdoff, mouse packet takes it back.
    quiet(105, 16'h0, 1'b0, 2'b00);
    mpkt(8'd3, 8'd0, 8'd0, 16'h0, 1'b0, 2'b00);
    quiet(12, 16'h0, 1'b0, 2'b00);

    // Deadzone boundary: +16 no switch, -128 switches; trigger held across the drain.
    quiet(105, 16'h0010, 1'b0, 2'b00);
    step(1'b0, {tog, 24'h0}, 16'h0080, 1'b1, 2'b00);
    quiet(15, 16'h0, 1'b1, 2'b00);
    quiet(2, 16'h0, 1'b0, 2'b00);
    quiet(3, 16'h0, 1'b1, 2'b00);
    quiet(2, 16'h0, 1'b0, 2'b00);

    // Force back to mouse, then simultaneous activity with saturated idle, then force overrides.
    quiet(3, 16'h0, 1'b0, 2'b01);
    quiet(110, 16'h0, 1'b0, 2'b00);
    mpkt(8'd1, 8'd0, 8'd0, 16'h0028, 1'b0, 2'b00);
    quiet(3, 16'h0, 1'b0, 2'b00);
    quiet(1, 16'h0, 1'b0, 2'b10);
    quiet(2, 16'h0, 1'b0, 2'b00);
    quiet(1, 16'h0, 1'b0, 2'b01);
    quiet(12, 16'h0, 1'b0, 2'b00);

    // Reset in the middle of a drain.
    quiet(1, 16'h0, 1'b0, 2'b10);
    quiet(4, 16'h0, 1'b0, 2'b00);
    step(1'b1, {tog, 24'h0}, 16'h0, 1'b0, 2'b00);
    #1;
    check_zero("async_reset_mid_xfer");
    step(1'b1, {tog, 24'h0}, 16'h0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      mpkt(8'd9, 8'd1, 8'd1, 16'h0, 1'b0, 2'b00);
      quiet(1, 16'h0, 1'b0, 2'b00);
    end

    // Random activity blocks.
    for (int b = 0; b < 25; b++) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(10, 140);
      bfs  = (kind == 3) ? 2'($urandom_range(0, 3)) : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
      for (int i = 0; i < len; i++) begin
        if (kind == 1) an = 16'($urandom);
        else begin
          sb = 8'($urandom_range(0, 32) - 16);
          an[7:0] = sb;
          sb = 8'($urandom_range(0, 32) - 16);
          an[15:8] = sb;
        end
        tr = (kind == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (kind == 0 && $urandom_range(0, 1) == 1)
          mpkt(8'($urandom_range(0, 3)), 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), an, tr, bfs);
        else if (kind != 0 && $urandom_range(0, 7) == 0)
          mpkt(8'h0, 8'h0, 8'h0, an, tr, bfs);
        else
          step(1'b0, {tog, 24'h0}, an, tr, bfs);
      end
    end

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
